// File: rtl/avst_packets_to_bytes_pkg.sv
// Shared constants, FSM state encoding and escape helper for the packets-to-bytes encoder.
// AVST_P2B_CHANNEL_EN adds the CHAN/CHAN_VAL states used for channel insertion.
package avst_p2b_pkg;

  localparam logic [7:0] SOP_MARK  = 8'h7A;
  localparam logic [7:0] EOP_MARK  = 8'h7B;
  localparam logic [7:0] CHAN_MARK = 8'h7C;
  localparam logic [7:0] ESC_MARK  = 8'h7D;
  localparam logic [7:0] ESC_XOR   = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
`ifdef AVST_P2B_CHANNEL_EN
    ST_CHAN     = 3'd1,
    ST_CHAN_VAL = 3'd2,
`endif
    ST_SOP      = 3'd3,
    ST_EOP      = 3'd4,
    ST_ESC      = 3'd5,
    ST_DATA     = 3'd6
  } state_t;

  // One FSM step: the state entered, the byte it presents, and what an ESC precedes.
  typedef struct packed {
    state_t     state;
    logic [7:0] val;
    logic       esc_chan;
  } step_t;

  function automatic logic needs_escape(input logic [7:0] b);
    return (b >= SOP_MARK) && (b <= ESC_MARK);
  endfunction

endpackage

// File: rtl/avst_packets_to_bytes_if.sv
// Packet-beat sink plus byte-stream source bundle for avst_packets_to_bytes.
interface avst_packets_to_bytes_if #(
  parameter int CHANNEL_W = 8
);
  logic                 i_valid;
  logic [7:0]           i_data;
  logic                 i_sop;
  logic                 i_eop;
  logic [CHANNEL_W-1:0] i_channel;
  logic                 o_ready;
  logic                 o_valid;
  logic [7:0]           o_data;
  logic                 i_out_ready;

  modport slave (
    input  i_valid, i_data, i_sop, i_eop, i_channel, i_out_ready,
    output o_ready, o_valid, o_data
  );

  modport master (
    output i_valid, i_data, i_sop, i_eop, i_channel, i_out_ready,
    input  o_ready, o_valid, o_data
  );
endinterface

// File: rtl/avst_packets_to_bytes.sv
// Encodes Avalon-ST packet beats into the escaped marker byte stream.
// Define AVST_P2B_CHANNEL_EN to insert CHAN markers on channel changes.
module avst_packets_to_bytes
  import avst_p2b_pkg::*;
#(
  parameter int CHANNEL_W = 8
) (
  input logic                     i_clk,
  input logic                     i_reset_n,
  avst_packets_to_bytes_if.slave  bus
);

  state_t     state_r;
  logic       valid_r;
  logic [7:0] out_r;
  logic [7:0] data_r;
  logic       sop_r;
  logic       eop_r;
  logic       esc_chan_r;

  logic [CHANNEL_W-1:0] chan_raw_s;
  logic [7:0]           chan_in_s;
  logic [7:0]           chan_hold_s;
  logic                 chan_pend_s;
  logic                 accept_s;
  step_t                accept_step_s;
  step_t                take_step_s;

`ifdef AVST_P2B_CHANNEL_EN
  logic [7:0] chan_r;
  logic [7:0] last_chan_r;
  logic       chan_sent_r;
`else
  logic       unused_chan_s;
`endif

  // Given the byte just completed (IDLE = beat just accepted), pick the next byte to present.
  function automatic step_t advance(
    input state_t     cur,
    input logic       esc_chan,
    input logic       chan_pend,
    input logic       sop,
    input logic       eop,
    input logic [7:0] chan8,
    input logic [7:0] data
  );
    step_t s;
    logic  want_sop;
    logic  want_eop;
    logic  want_data;
    s         = '{state: ST_IDLE, val: 8'h00, esc_chan: 1'b0};
    want_sop  = 1'b0;
    want_eop  = 1'b0;
    want_data = 1'b0;
    case (cur)
      ST_IDLE: begin
        if (chan_pend) begin
`ifdef AVST_P2B_CHANNEL_EN
          s.state = ST_CHAN;
          s.val   = CHAN_MARK;
`else
          s.state = ST_IDLE;
          s.val   = 8'h00;
`endif
        end else begin
          want_sop  = sop;
          want_eop  = eop;
          want_data = 1'b1;
        end
      end
`ifdef AVST_P2B_CHANNEL_EN
      ST_CHAN: begin
        if (needs_escape(chan8)) begin
          s.state    = ST_ESC;
          s.val      = ESC_MARK;
          s.esc_chan = 1'b1;
        end else begin
          s.state = ST_CHAN_VAL;
          s.val   = chan8;
        end
      end
      ST_CHAN_VAL: begin
        want_sop  = sop;
        want_eop  = eop;
        want_data = 1'b1;
      end
`endif
      ST_SOP: begin
        want_eop  = eop;
        want_data = 1'b1;
      end
      ST_EOP: begin
        want_data = 1'b1;
      end
      ST_ESC: begin
        s.val   = (esc_chan ? chan8 : data) ^ ESC_XOR;
        s.state = ST_DATA;
`ifdef AVST_P2B_CHANNEL_EN
        if (esc_chan) begin
          s.state = ST_CHAN_VAL;
        end else begin
          s.state = ST_DATA;
        end
`endif
      end
      ST_DATA: begin
        s.state = ST_IDLE;
        s.val   = 8'h00;
      end
      default: begin
        s.state = ST_IDLE;
        s.val   = 8'h00;
      end
    endcase

    if (want_sop) begin
      s.state = ST_SOP;
      s.val   = SOP_MARK;
    end else if (want_eop) begin
      s.state = ST_EOP;
      s.val   = EOP_MARK;
    end else if (want_data) begin
      if (needs_escape(data)) begin
        s.state    = ST_ESC;
        s.val      = ESC_MARK;
        s.esc_chan = 1'b0;
      end else begin
        s.state = ST_DATA;
        s.val   = data;
      end
    end else begin
      s.esc_chan = s.esc_chan;
    end
    return s;
  endfunction

  assign bus.o_ready = i_reset_n & (state_r == ST_IDLE) & ~valid_r;
  assign bus.o_valid = valid_r;
  assign bus.o_data  = out_r;
  assign accept_s    = bus.i_valid & bus.o_ready;
  assign chan_raw_s  = bus.i_channel;

`ifdef AVST_P2B_CHANNEL_EN
  assign chan_in_s   = 8'(chan_raw_s);
  assign chan_pend_s = ~chan_sent_r | (chan_in_s != last_chan_r);
  assign chan_hold_s = chan_r;
`else
  assign unused_chan_s = ^chan_raw_s;
  assign chan_in_s     = 8'h00;
  assign chan_pend_s   = 1'b0;
  assign chan_hold_s   = 8'h00;
`endif

  // Next-step decode for a fresh accept and for the byte currently being taken.
  always_comb begin
    accept_step_s = advance(ST_IDLE, 1'b0, chan_pend_s, bus.i_sop, bus.i_eop,
                            chan_in_s, bus.i_data);
    take_step_s   = advance(state_r, esc_chan_r, 1'b0, sop_r, eop_r,
                            chan_hold_s, data_r);
  end

  // Encoder FSM with holding registers and registered byte output.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_r     <= ST_IDLE;
      valid_r     <= 1'b0;
      out_r       <= 8'h00;
      data_r      <= 8'h00;
      sop_r       <= 1'b0;
      eop_r       <= 1'b0;
      esc_chan_r  <= 1'b0;
`ifdef AVST_P2B_CHANNEL_EN
      chan_r      <= 8'h00;
      last_chan_r <= 8'h00;
      chan_sent_r <= 1'b0;
`endif
    end else if (accept_s) begin
      data_r      <= bus.i_data;
      sop_r       <= bus.i_sop;
      eop_r       <= bus.i_eop;
      state_r     <= accept_step_s.state;
      out_r       <= accept_step_s.val;
      esc_chan_r  <= accept_step_s.esc_chan;
      valid_r     <= 1'b1;
`ifdef AVST_P2B_CHANNEL_EN
      chan_r      <= chan_in_s;
      last_chan_r <= chan_in_s;
      chan_sent_r <= 1'b1;
`endif
    end else if (valid_r && bus.i_out_ready) begin
      state_r    <= take_step_s.state;
      out_r      <= take_step_s.val;
      esc_chan_r <= take_step_s.esc_chan;
      valid_r    <= (take_step_s.state != ST_IDLE);
    end else begin
      state_r <= state_r;
      valid_r <= valid_r;
      out_r   <= out_r;
    end
  end

endmodule

// File: tb/tb_avst_packets_to_bytes.sv
// Scoreboard bench: beats are encoded by a list-based model into an expected byte queue,
// and a monitor pops and compares every byte the encoder hands over.
module tb_avst_packets_to_bytes;

  localparam int CW = 8;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   rdy_mode;
  logic [7:0] exp_q[$];
  logic       m_sent;
  logic [7:0] m_last;

  avst_packets_to_bytes_if #(.CHANNEL_W(CW)) bus ();

  avst_packets_to_bytes #(.CHANNEL_W(CW)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void push_val(input logic [7:0] b);
    if (b >= 8'h7A && b <= 8'h7D) begin
      exp_q.push_back(8'h7D);
      exp_q.push_back(b ^ 8'h20);
    end else begin
      exp_q.push_back(b);
    end
  endfunction

  function automatic void model_beat(input logic [7:0] d, input logic s, input logic e,
                                     input logic [CW-1:0] ch);
    logic [7:0] ch8;
    ch8 = 8'(ch);
`ifdef AVST_P2B_CHANNEL_EN
    if (!m_sent || ch8 != m_last) begin
      exp_q.push_back(8'h7C);
      push_val(ch8);
    end
    m_sent = 1'b1;
`endif
    m_last = ch8;
    if (s) exp_q.push_back(8'h7A);
    if (e) exp_q.push_back(8'h7B);
    push_val(d);
  endfunction

  task automatic send_beat(input logic [7:0] d, input logic s, input logic e,
                           input logic [CW-1:0] ch);
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    @(negedge clk);
    bus.i_valid   = 1'b1;
    bus.i_data    = d;
    bus.i_sop     = s;
    bus.i_eop     = e;
    bus.i_channel = ch;
    while (!done) begin
      #2;
      if (bus.o_ready) begin
        model_beat(d, s, e, ch);
        done = 1'b1;
      end else if (n >= 500) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: beat data=%0h not accepted", d);
        done = 1'b1;
      end
      n++;
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    m_sent = 1'b0;
    m_last = 8'h00;
    repeat (cycles) @(negedge clk);
    #1;
    check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_ready", {31'd0, bus.o_ready}, 32'd0);
    check("rst_data",  {24'd0, bus.o_data},  32'd0);
    rst_n = 1'b1;
    #2;
    check("ready_after_rst", {31'd0, bus.o_ready}, 32'd1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check({name, "_idle_valid"}, {31'd0, bus.o_valid}, 32'd0);
  endtask

  // Downstream ready generator: always-ready, random, or left to the main sequence.
  initial begin
    forever begin
      @(negedge clk);
      if (rdy_mode == 0) bus.i_out_ready = 1'b1;
      else if (rdy_mode == 1) bus.i_out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pop and compare each handed-over byte, and check stability while stalled.
  initial begin
    logic       prev_hold;
    logic [7:0] prev_data;
    logic [7:0] e;
    prev_hold = 1'b0;
    prev_data = 8'h00;
    forever begin
      @(negedge clk);
      #2;
      if (prev_hold) begin
        check("hold_valid", {31'd0, bus.o_valid}, 32'd1);
        check("hold_data", {24'd0, bus.o_data}, {24'd0, prev_data});
      end
      if (rst_n && bus.o_valid && bus.i_out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: actual=%0h expected=none", bus.o_data);
        end else begin
          e = exp_q.pop_front();
          check("byte", {24'd0, bus.o_data}, {24'd0, e});
        end
      end
      prev_hold = rst_n && bus.o_valid && !bus.i_out_ready;
      prev_data = bus.o_data;
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rdy_mode = 0;
    rst_n = 1'b0;
    m_sent = 1'b0;
    m_last = 8'h00;
    bus.i_valid = 1'b0;
    bus.i_data = 8'h00;
    bus.i_sop = 1'b0;
    bus.i_eop = 1'b0;
    bus.i_channel = '0;
    bus.i_out_ready = 1'b1;

    do_reset(3);

    send_beat(8'h41, 1'b1, 1'b1, 8'h00);
    drain("single");

    send_beat(8'h01, 1'b1, 1'b0, 8'h00);
    send_beat(8'h7B, 1'b0, 1'b0, 8'h00);
    send_beat(8'h02, 1'b0, 1'b1, 8'h00);
    drain("packet3");

    // Stall downstream while the ESC of a 0x7D data byte is presented.
    rdy_mode = 2;
    @(negedge clk);
    bus.i_out_ready = 1'b0;
    send_beat(8'h7D, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      #2;
      check("stall_valid", {31'd0, bus.o_valid}, 32'd1);
      check("stall_esc", {24'd0, bus.o_data}, 32'h7D);
      @(negedge clk);
    end
    bus.i_out_ready = 1'b1;
    rdy_mode = 0;
    drain("stall");

    send_beat(8'h10, 1'b1, 1'b1, 8'h7D);
    drain("chan7d");

    // Reset in the middle of a partially emitted beat.
    rdy_mode = 2;
    @(negedge clk);
    bus.i_out_ready = 1'b0;
    send_beat(8'h7A, 1'b1, 1'b0, 8'h03);
    @(negedge clk);
    bus.i_out_ready = 1'b1;
    do_reset(1);
    rdy_mode = 0;
    send_beat(8'h55, 1'b1, 1'b1, 8'h00);
    drain("post_reset");

    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      logic [7:0] d;
      logic [7:0] c;
      if ($urandom_range(0, 1) == 0) d = 8'(8'h78 + $urandom_range(0, 7));
      else d = 8'($urandom);
      case ($urandom_range(0, 5))
        0: c = 8'h00;
        1: c = 8'h01;
        2: c = 8'(8'h7A + $urandom_range(0, 3));
        3: c = 8'hFF;
        default: c = m_last;
      endcase
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      send_beat(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c);
    end
    rdy_mode = 0;
    drain("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/avst_packets_to_bytes.md
AVST_PACKETS_TO_BYTES -- requirements
Module: avst_packets_to_bytes

Interface
REQ-001 SHALL have parameter CHANNEL_W, default 8, meaning channel field width (1..8).
REQ-002 SHALL have port i_clk  input  1  meaning sole clock; all logic on rising edge.
REQ-003 SHALL have port i_reset_n  input  1  meaning synchronous, active-low reset.
REQ-004 SHALL have port i_valid  input  1  meaning packet beat valid.
REQ-005 SHALL have port i_data  input  8  meaning packet beat payload byte.
REQ-006 SHALL have port i_sop  input  1  meaning beat is first of packet.
REQ-007 SHALL have port i_eop  input  1  meaning beat is last of packet.
REQ-008 SHALL have port i_channel  input  CHANNEL_W  meaning beat channel.
REQ-009 SHALL have port o_ready  output  1  meaning beat accepted when i_valid & o_ready.
REQ-010 SHALL have port o_valid  output  1  meaning output byte valid.
REQ-011 SHALL have port o_data  output  8  meaning encoded byte stream.
REQ-012 SHALL have port i_out_ready  input  1  meaning downstream sink (serial transmitter not-busy) takes byte when o_valid & i_out_ready.

Function
REQ-013 SHALL encode packets into the byte stream understood by the team's bytes-to-packets decoder: SOP=0x7A, EOP=0x7B, CHAN=0x7C, ESC=0x7D.
REQ-014 SHALL emit per accepted beat, in order: [CHAN, channel byte] if channel differs from last emitted channel or none emitted since reset; [SOP] if i_sop; [EOP] if i_eop; then the data byte.
REQ-015 SHALL escape any channel or data byte in 0x7A..0x7D as ESC followed by byte XOR 0x20; marker bytes are never escaped.
REQ-016 SHALL zero-extend the channel to 8 bits before comparison and escape.
REQ-017 SHALL implement FSM states IDLE, CHAN, CHAN_VAL, SOP, EOP, ESC, DATA; IDLE->first required state on accept; each state advances only on o_valid & i_out_ready; the state emitting the data byte returns to IDLE.
REQ-018 SHALL assert o_ready only in IDLE with no byte pending; the accepted beat is captured into holding registers in that same cycle.
REQ-019 SHALL present the first byte of a beat with o_valid=1 the cycle after acceptance (latency 1).
REQ-020 SHALL hold o_data and o_valid stable while o_valid=1 and i_out_ready=0.
REQ-021 SHALL deassert o_valid the cycle after the final byte of a beat is taken unless a new beat is accepted.
REQ-022 SHALL not check SOP/EOP framing; sop and eop on one beat yield both markers.

Reset
REQ-023 SHALL, while i_reset_n=0, force o_valid=0, o_ready=0, o_data=0x00, state IDLE, and clear the channel-sent flag.
REQ-024 SHALL discard any partially emitted byte sequence on reset; no byte after reset belongs to a pre-reset beat.
REQ-025 SHALL assert o_ready the first cycle after i_reset_n returns high.

Configuration
REQ-026 SHALL, with macro AVST_P2B_CHANNEL_EN defined, implement channel insertion per REQ-014..016.
REQ-027 SHALL, without AVST_P2B_CHANNEL_EN, ignore i_channel, never emit CHAN, and omit the CHAN/CHAN_VAL states and channel registers.

Structure
REQ-028 SHALL place marker constants, the 0x20 escape mask, the FSM state enum and a needs-escape function in shared package avst_p2b_pkg.
REQ-029 SHALL be a single module; no sub-module is warranted.

Verification
REQ-030 Reset, beat ch0 sop+eop data 0x41 -> bytes 7C 00 7A 7B 41, o_valid low afterwards.
REQ-031 Then ch0 packet 01,7B,02 (sop first, eop last) -> 7A 01 7D 5B 7B 02, no CHAN.
REQ-032 Beat data 0x7D, i_out_ready low 5 cycles while ESC shown -> o_data held 0x7D, then 7D 5D, nothing lost.
REQ-033 Channel change to 0x7D on single-beat packet data 0x10 -> 7C 7D 5D 7A 7B 10.
REQ-034 i_reset_n low 1 cycle mid-packet -> o_valid 0 next cycle; next ch0 beat re-emits 7C 00.
REQ-035 Macro undefined, stimulus of REQ-030 -> 7A 7B 41 only.
